pipeline_control: RTL and testbench

Sequences the five-stage pipeline latches by turning hazard, redirect and memory-handshake conditions into per-stage enable and flush strobes. Sits between the hazard unit and cache interfaces on one side and the PC and pipeline registers on the other. Owns the halt sequence, including the dcache flush handshake, and optionally counts stall and flush events.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/pipe_perf_counter.sv | 19 +
 rtl/pipeline_control.sv | 132 +++++++++++++
 tb/tb_pipeline_control.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: pipeline-control FSM states and the per-stage strobe bundle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_strobe_t;

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating event counter: counts one per cycle while inc is high, sticks at all-ones.
module pipe_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Five-stage pipeline sequencer: stage enables/flushes, halt + dcache flush handshake.
// Optional stall/flush perf counters when PIPE_PERF_CNT_EN is defined (ports tied to 0 otherwise).
import cpu_types_pkg::*;

module pipeline_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hazard,
  input  logic             branch,
  input  logic             jump,
  input  logic             ihit,
  input  logic             mem_dreq,
  input  logic             dhit,
  input  logic             mem_halt,
  input  logic             flush_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             dflush_req,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  pipe_ctrl_state_t state, state_nxt;
  pipe_strobe_t     str;
  logic             stall_inc, flush_inc, halt_q;

  // Hazard / redirect / normal-fetch rules shared by RUN and the DSTALL release cycle.
  function automatic pipe_strobe_t issue_rules(input logic hz, input logic redir, input logic hit);
    pipe_strobe_t s;
    s = '0;
    if (hz) begin
      s.idex_flush = 1'b1;
      s.exmem_en   = 1'b1;
      s.memwb_en   = 1'b1;
    end else if (redir) begin
      s.pc_en      = 1'b1;
      s.ifid_flush = 1'b1;
      s.idex_en    = 1'b1;
      s.exmem_en   = 1'b1;
      s.memwb_en   = 1'b1;
    end else begin
      s.pc_en      = hit;
      s.ifid_en    = hit;
      s.ifid_flush = !hit;
      s.idex_en    = 1'b1;
      s.exmem_en   = 1'b1;
      s.memwb_en   = 1'b1;
    end
    return s;
  endfunction

  always_comb begin
    str        = '0;
    dflush_req = 1'b0;
    state_nxt  = state;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (!RST) begin
      case (state)
        RUN: begin
          if (mem_dreq && !dhit) begin
            state_nxt = DSTALL;
            stall_inc = 1'b1;
          end else if (mem_halt) begin
            str.memwb_en    = 1'b1;
            str.ifid_flush  = 1'b1;
            str.idex_flush  = 1'b1;
            str.exmem_flush = 1'b1;
            state_nxt       = DRAIN;
          end else begin
            str       = issue_rules(hazard, branch | jump, ihit);
            stall_inc = hazard;
            flush_inc = !hazard && (branch || jump);
          end
        end
        DSTALL: begin
          if (!dhit) begin
            stall_inc = 1'b1;
          end else begin
            str       = issue_rules(hazard, branch | jump, ihit);
            stall_inc = hazard;
            flush_inc = !hazard && (branch || jump);
            state_nxt = RUN;
          end
        end
        DRAIN: begin
          dflush_req = !flush_done;
          if (flush_done) state_nxt = HALTED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      halt_q <= (state_nxt == HALTED);
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
          ifid_flush, idex_flush, exmem_flush} = str;
  assign halt = halt_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(CLK), .clear(RST), .inc(stall_inc), .count(stall_cycles)
  );
  pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(CLK), .clear(RST), .inc(flush_inc), .count(flush_count)
  );
`else
  logic unused_perf;
  assign unused_perf  = stall_inc | flush_inc;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed, table-driven check of pipeline_control strobes, halt handshake, reset and counters.
module tb_pipeline_control;
  import cpu_types_pkg::*;

  localparam int TB_CNT_W = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic hazard, branch, jump, ihit, mem_dreq, dhit, mem_halt, flush_done;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, dflush_req, halt;
  logic [TB_CNT_W-1:0] stall_cycles, flush_count;

  pipeline_control #(.CNT_W(TB_CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .hazard(hazard), .branch(branch), .jump(jump), .ihit(ihit),
    .mem_dreq(mem_dreq), .dhit(dhit), .mem_halt(mem_halt), .flush_done(flush_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .dflush_req(dflush_req), .halt(halt),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  // Input byte: {hazard, branch, jump, ihit, mem_dreq, dhit, mem_halt, flush_done}
  // Strobe byte: {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f}
  typedef struct {
    logic [7:0] in;
    logic [7:0] str;
    logic       dfl;
    logic       hlt;
    int         stall;
    int         flush;
    string      name;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  vec_t tbl[15];

  logic [7:0] str_act;
  assign str_act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

  function automatic vec_t mk(input logic [7:0] in, input logic [7:0] s, input logic d,
                              input logic h, input int st, input int fl, input string nm);
    vec_t v;
    v.in = in; v.str = s; v.dfl = d; v.hlt = h; v.stall = st; v.flush = fl; v.name = nm;
    return v;
  endfunction

  function automatic logic [31:0] ce(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_in(input logic [7:0] in);
    {hazard, branch, jump, ihit, mem_dreq, dhit, mem_halt, flush_done} = in;
  endtask

  // Called just after a rising edge: drive, check comb outputs mid-cycle, clock, check counters.
  task automatic step(input vec_t v);
    set_in(v.in);
    @(negedge CLK);
    chk({v.name, ".strobes"}, {24'd0, str_act}, {24'd0, v.str});
    chk({v.name, ".dflush_req"}, {31'd0, dflush_req}, {31'd0, v.dfl});
    chk({v.name, ".halt"}, {31'd0, halt}, {31'd0, v.hlt});
    @(posedge CLK); #1;
    chk({v.name, ".stall_cycles"}, {28'd0, stall_cycles}, ce(v.stall));
    chk({v.name, ".flush_count"}, {28'd0, flush_count}, ce(v.flush));
  endtask

  task automatic do_reset(input logic [7:0] in, input string nm);
    RST = 1'b1;
    set_in(in);
    @(negedge CLK);
    chk({nm, ".rst_strobes"}, {24'd0, str_act}, 32'd0);
    chk({nm, ".rst_dflush_req"}, {31'd0, dflush_req}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk({nm, ".rst_halt"}, {31'd0, halt}, 32'd0);
    chk({nm, ".rst_stall"}, {28'd0, stall_cycles}, 32'd0);
    chk({nm, ".rst_flush"}, {28'd0, flush_count}, 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(8'b0001_0000, 8'b11111_000, 0, 0, 0, 0, "normal");
    tbl[1]  = mk(8'b0000_0000, 8'b00111_100, 0, 0, 0, 0, "imiss");
    tbl[2]  = mk(8'b0000_1000, 8'b00000_000, 0, 0, 1, 0, "dmiss_run");
    tbl[3]  = mk(8'b0000_1000, 8'b00000_000, 0, 0, 2, 0, "dstall1");
    tbl[4]  = mk(8'b0000_1000, 8'b00000_000, 0, 0, 3, 0, "dstall2");
    tbl[5]  = mk(8'b0001_1100, 8'b11111_000, 0, 0, 3, 0, "dhit_release");
    tbl[6]  = mk(8'b1001_0000, 8'b00011_010, 0, 0, 4, 0, "hazard1");
    tbl[7]  = mk(8'b1001_0000, 8'b00011_010, 0, 0, 5, 0, "hazard2");
    tbl[8]  = mk(8'b0100_0000, 8'b10111_100, 0, 0, 5, 1, "branch");
    tbl[9]  = mk(8'b1011_0000, 8'b00011_010, 0, 0, 6, 1, "hazard_over_jump");
    tbl[10] = mk(8'b0011_0000, 8'b10111_100, 0, 0, 6, 2, "jump");
    tbl[11] = mk(8'b1000_1000, 8'b00000_000, 0, 0, 7, 2, "dmiss_over_hazard");
    tbl[12] = mk(8'b0100_1100, 8'b10111_100, 0, 0, 7, 3, "dhit_branch");
    tbl[13] = mk(8'b0001_1100, 8'b11111_000, 0, 0, 7, 3, "dreq_hit");
    tbl[14] = mk(8'b0001_0010, 8'b00001_111, 0, 0, 7, 3, "mem_halt");

    RST = 1'b1;
    set_in(8'd0);
    @(posedge CLK); #1;
    do_reset(8'b0001_0000, "reset0");

    for (int i = 0; i < 15; i++) step(tbl[i]);

    // DRAIN: flush_done low for 4 cycles, counters must hold despite hazard/dmiss inputs
    for (int i = 0; i < 4; i++) step(mk(8'b1101_1000, 8'b00000_000, 1, 0, 7, 3, "drain_wait"));
    step(mk(8'b0000_0001, 8'b00000_000, 0, 0, 7, 3, "drain_done"));
    for (int i = 0; i < 11; i++) step(mk(8'b1111_1111, 8'b00000_000, 0, 1, 7, 3, "halted"));

    // Reset out of HALTED, then minimum 3-cycle halt sequence
    do_reset(8'b0001_0000, "reset_halted");
    step(mk(8'b0001_0010, 8'b00001_111, 0, 0, 0, 0, "min_mem_halt"));
    step(mk(8'b0000_0001, 8'b00000_000, 0, 0, 0, 0, "min_drain"));
    step(mk(8'b0001_0000, 8'b00000_000, 0, 1, 0, 0, "min_halted"));

    // Reset in the middle of DRAIN after some counted events
    do_reset(8'd0, "reset_pre_drain");
    step(mk(8'b1001_0000, 8'b00011_010, 0, 0, 1, 0, "pre_hz1"));
    step(mk(8'b0101_0000, 8'b10111_100, 0, 0, 1, 1, "pre_br"));
    step(mk(8'b0001_0010, 8'b00001_111, 0, 0, 1, 1, "pre_mem_halt"));
    step(mk(8'b0000_0000, 8'b00000_000, 1, 0, 1, 1, "mid_drain1"));
    step(mk(8'b0000_0000, 8'b00000_000, 1, 0, 1, 1, "mid_drain2"));
    do_reset(8'b0000_0000, "reset_mid_drain");
    step(mk(8'b0001_0000, 8'b11111_000, 0, 0, 0, 0, "after_drain_rst"));

    // Saturation of both counters
    for (int k = 1; k <= 20; k++)
      step(mk(8'b1000_0000, 8'b00011_010, 0, 0, sat(k), 0, "sat_stall"));
    for (int k = 1; k <= 17; k++)
      step(mk(8'b0100_0000, 8'b10111_100, 0, 0, 15, sat(k), "sat_flush"));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
